// File: rtl/tap_controller.sv
// -----------------------------------------------------------------------------
// tap_controller
//   IEEE 1149.1-style TAP controller with instruction register for an EXTEST
//   boundary-scan chain. Decodes TMS into the 16-state TAP FSM, owns the
//   instruction shift/update registers and the BYPASS bit, and drives the
//   boundary-scan cell control lines plus the TDO output mux.
//
// Ports
//   CLK        in   test clock (TCK), all state changes on the rising edge
//   Rst        in   asynchronous active-high reset
//   TMS        in   test mode select
//   TDI        in   serial test data in
//   BSR_TDO    in   serial out of the last boundary-scan cell
//   TDO        out  serial test data out (combinational mux)
//   TDO_En     out  enable for the tristate TDO driver (Shift-IR / Shift-DR)
//   CaptureDR  out  boundary cell capture enable (Capture-DR, chain selected)
//   ShiftDR    out  boundary cell shift-mux select (Shift-DR, chain selected)
//   UpdateDR   out  boundary cell update-FF enable (Update-DR, chain selected)
//   Mode       out  boundary cell output-mux select (IR == EXTEST)
//   IR         out  current (updated) instruction
//   State      out  current TAP state encoding
// -----------------------------------------------------------------------------
module tap_controller #(
  parameter int                  IR_WIDTH    = 4,
  parameter logic [IR_WIDTH-1:0] EXTEST_CODE = '0,
  parameter logic [IR_WIDTH-1:0] SAMPLE_CODE = IR_WIDTH'(1),
  parameter logic [IR_WIDTH-1:0] BYPASS_CODE = '1
) (
  input  logic                CLK,
  input  logic                Rst,
  input  logic                TMS,
  input  logic                TDI,
  input  logic                BSR_TDO,
  output logic                TDO,
  output logic                TDO_En,
  output logic                CaptureDR,
  output logic                ShiftDR,
  output logic                UpdateDR,
  output logic                Mode,
  output logic [IR_WIDTH-1:0] IR,
  output logic [3:0]          State
);

  typedef enum logic [3:0] {
    TLR    = 4'hF,
    RTI    = 4'hC,
    SEL_DR = 4'h7,
    CAP_DR = 4'h6,
    SH_DR  = 4'h2,
    EX1_DR = 4'h1,
    PS_DR  = 4'h3,
    EX2_DR = 4'h0,
    UPD_DR = 4'h5,
    SEL_IR = 4'h4,
    CAP_IR = 4'hE,
    SH_IR  = 4'hA,
    EX1_IR = 4'h9,
    PS_IR  = 4'hB,
    EX2_IR = 4'h8,
    UPD_IR = 4'hD
  } tap_state_e;

  tap_state_e          state_q, state_d;
  logic [IR_WIDTH-1:0] ir_q, ir_d;
  logic [IR_WIDTH-1:0] ir_shift_q, ir_shift_d;
  logic                bypass_q, bypass_d;
  logic                boundary_sel;

  // ---------------------------------------------------------------------------
  // State and data registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge Rst) begin
    if (Rst) begin
      state_q    <= TLR;
      ir_q       <= BYPASS_CODE;
      ir_shift_q <= '0;
      bypass_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      ir_shift_q <= ir_shift_d;
      bypass_q   <= bypass_d;
    end
  end

  // ---------------------------------------------------------------------------
  // TAP next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      TLR:     state_d = TMS ? TLR    : RTI;
      RTI:     state_d = TMS ? SEL_DR : RTI;
      SEL_DR:  state_d = TMS ? SEL_IR : CAP_DR;
      CAP_DR:  state_d = TMS ? EX1_DR : SH_DR;
      SH_DR:   state_d = TMS ? EX1_DR : SH_DR;
      EX1_DR:  state_d = TMS ? UPD_DR : PS_DR;
      PS_DR:   state_d = TMS ? EX2_DR : PS_DR;
      EX2_DR:  state_d = TMS ? UPD_DR : SH_DR;
      UPD_DR:  state_d = TMS ? SEL_DR : RTI;
      SEL_IR:  state_d = TMS ? TLR    : CAP_IR;
      CAP_IR:  state_d = TMS ? EX1_IR : SH_IR;
      SH_IR:   state_d = TMS ? EX1_IR : SH_IR;
      EX1_IR:  state_d = TMS ? UPD_IR : PS_IR;
      PS_IR:   state_d = TMS ? EX2_IR : PS_IR;
      EX2_IR:  state_d = TMS ? UPD_IR : SH_IR;
      UPD_IR:  state_d = TMS ? SEL_DR : RTI;
      default: state_d = TLR;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Instruction and bypass registers
  // ---------------------------------------------------------------------------
  always_comb begin
    ir_shift_d = ir_shift_q;
    ir_d       = ir_q;
    bypass_d   = bypass_q;

    case (state_q)
      // Capture pattern ends in 2'b01 so a broken chain is visible on TDO.
      CAP_IR:  ir_shift_d = IR_WIDTH'(2'b01);
      SH_IR:   ir_shift_d = {TDI, ir_shift_q[IR_WIDTH-1:1]};
      UPD_IR:  ir_d       = ir_shift_q;
      CAP_DR:  bypass_d   = 1'b0;
      SH_DR:   bypass_d   = TDI;
      default: ;
    endcase

    // Any TMS-driven entry into Test-Logic-Reset falls back to BYPASS.
    if (state_d == TLR) begin
      ir_d = BYPASS_CODE;
    end
  end

  // ---------------------------------------------------------------------------
  // Moore output decode
  // ---------------------------------------------------------------------------
  // Undefined opcodes fall through to the bypass chain.
  assign boundary_sel = (ir_q == EXTEST_CODE) || (ir_q == SAMPLE_CODE);

  always_comb begin
    TDO       = 1'b0;
    TDO_En    = 1'b0;
    CaptureDR = 1'b0;
    ShiftDR   = 1'b0;
    UpdateDR  = 1'b0;
    Mode      = (ir_q == EXTEST_CODE);

    case (state_q)
      SH_IR: begin
        TDO    = ir_shift_q[0];
        TDO_En = 1'b1;
      end
      SH_DR: begin
        TDO     = boundary_sel ? BSR_TDO : bypass_q;
        TDO_En  = 1'b1;
        ShiftDR = boundary_sel;
      end
      CAP_DR:  CaptureDR = boundary_sel;
      UPD_DR:  UpdateDR  = boundary_sel;
      default: ;
    endcase
  end

  assign IR    = ir_q;
  assign State = state_q;

endmodule
